// File: rtl/xswitches_pkg.sv
// xswitches_pkg: shared sizing helpers and parameter legality check for the
// debounced switch/button input peripheral.
//   CNT_W(stable_ticks)  width of a per-bit debounce counter
//   PRE_W(tick_div)      width of the shared tick prescaler
//   params_legal(...)    1 when the parameter set is usable
package xswitches_pkg;

  // Counter must hold 0..stable_ticks.
  function automatic int CNT_W(input int stable_ticks);
    return $clog2(stable_ticks + 32'sd1);
  endfunction

  // Prescaler counts 0..tick_div-1.
  function automatic int PRE_W(input int tick_div);
    return $clog2(tick_div);
  endfunction

  // A one-cycle prescaler would tick every cycle, so at least two cycles per
  // tick and at least one tick of confirmation are required.
  function automatic bit params_legal(input int width, input int tick_div,
                                      input int stable_ticks);
    return (width >= 32'sd1) && (tick_div >= 32'sd2) && (stable_ticks >= 32'sd1);
  endfunction

endpackage

// File: rtl/xswitches_debounce_bit.sv
// debounce_bit: one input bit of the switch peripheral.
//   clk     system clock
//   reset   asynchronous, active-low reset
//   raw     raw pin level, asynchronous to clk
//   tick    shared debounce tick, one cycle wide
//   stable  debounced level (flop output)
//   rise    high in the cycle whose closing edge moves stable 0->1
module debounce_bit
  import xswitches_pkg::*;
#(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic stable,
  output logic rise
);

  localparam int CNT_BITS = CNT_W(STABLE_TICKS);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(32'd1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_TICKS - 32'sd1);

  logic                s1_r;
  logic                s2_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic                stable_r;
  logic [CNT_BITS-1:0] cnt_n_s;
  logic                stable_n_s;

  // Debounce next state: any cycle matching the held level restarts the count,
  // so a bounce must persist for STABLE_TICKS ticks in a row to be accepted.
  always_comb begin
    cnt_n_s    = cnt_r;
    stable_n_s = stable_r;
    if (s2_r == stable_r) begin
      cnt_n_s = CNT_ZERO;
    end else if (tick) begin
      if (cnt_r == CNT_LAST) begin
        stable_n_s = s2_r;
        cnt_n_s    = CNT_ZERO;
      end else begin
        cnt_n_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_n_s = cnt_r;
    end
  end

  // Synchroniser, debounce counter and stable level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      cnt_r    <= CNT_ZERO;
      stable_r <= 1'b0;
    end else begin
      s1_r     <= raw;
      s2_r     <= s1_r;
      cnt_r    <= cnt_n_s;
      stable_r <= stable_n_s;
    end
  end

  assign stable = stable_r;
  // Announced before the edge so the event flag can be set on the same edge.
  assign rise   = stable_n_s & ~stable_r;

endmodule

// File: rtl/xswitches.sv
// xswitches: debounced slide-switch / push-button input peripheral.
//   clk       system clock
//   reset     asynchronous, active-low reset
//   sw_in     raw pin levels (WIDTH), asynchronous to clk
//   rd_en     one-cycle read request
//   rd_sel    per-bit read / event-clear mask, sampled with rd_en
//   rd_data   masked debounced levels, valid with rd_valid
//   rd_valid  one-cycle pulse, the cycle after rd_en
//   sw_state  live debounced levels
//   evt       sticky rising-edge flags
//   irq       OR of evt
module xswitches
  import xswitches_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] evt,
  output logic             irq
);

  localparam int PRE_BITS = PRE_W(TICK_DIV);
  localparam logic [PRE_BITS-1:0] PRE_ZERO = {PRE_BITS{1'b0}};
  localparam logic [PRE_BITS-1:0] PRE_ONE  = PRE_BITS'(32'd1);
  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(TICK_DIV - 32'sd1);
  localparam logic [WIDTH-1:0]    W_ZERO   = {WIDTH{1'b0}};

  if (!params_legal(WIDTH, TICK_DIV, STABLE_TICKS)) begin : g_param_check
    $error("xswitches: WIDTH>=1, TICK_DIV>=2 and STABLE_TICKS>=1 are required");
  end

  logic [PRE_BITS-1:0] pre_r;
  logic [PRE_BITS-1:0] pre_n_s;
  logic                tick_s;
  logic [WIDTH-1:0]    stable_s;
  logic [WIDTH-1:0]    rise_s;
  logic [WIDTH-1:0]    clr_s;
  logic [WIDTH-1:0]    evt_r;
  logic [WIDTH-1:0]    evt_n_s;
  logic [WIDTH-1:0]    rd_data_r;
  logic [WIDTH-1:0]    rd_data_n_s;
  logic                rd_valid_r;

  assign tick_s = (pre_r == PRE_LAST);

  // Prescaler next count: wraps after TICK_DIV-1.
  always_comb begin
    pre_n_s = PRE_ZERO;
    if (tick_s) begin
      pre_n_s = PRE_ZERO;
    end else begin
      pre_n_s = pre_r + PRE_ONE;
    end
  end

  for (genvar i = 32'sd0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_in[i]),
      .tick  (tick_s),
      .stable(stable_s[i]),
      .rise  (rise_s[i])
    );
  end

  // Read snapshot and event update; set is applied after clear so a rise
  // coinciding with a clear of the same bit keeps the flag.
  always_comb begin
    clr_s       = W_ZERO;
    rd_data_n_s = rd_data_r;
    if (rd_en) begin
      clr_s       = rd_sel;
      rd_data_n_s = stable_s & rd_sel;
    end else begin
      clr_s       = W_ZERO;
      rd_data_n_s = rd_data_r;
    end
    evt_n_s = (evt_r & ~clr_s) | rise_s;
  end

  // Prescaler, event flags and read port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_r      <= PRE_ZERO;
      evt_r      <= W_ZERO;
      rd_data_r  <= W_ZERO;
      rd_valid_r <= 1'b0;
    end else begin
      pre_r      <= pre_n_s;
      evt_r      <= evt_n_s;
      rd_data_r  <= rd_data_n_s;
      rd_valid_r <= rd_en;
    end
  end

  assign sw_state = stable_s;
  assign evt      = evt_r;
  assign irq      = |evt_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule
